// File: rtl/uart_kernel_nios2_cpu_debug_mon_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_kernel_nios2_cpu_debug_mon_ram_ctrl_pkg
// Purpose  : Shared constants for the debug monitor RAM controller: jdo
//            field positions, register-space decode, status bit indices,
//            debug RAM depth and controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_kernel_nios2_cpu_debug_mon_ram_ctrl_pkg;

    // Debug RAM geometry
    localparam int c_ram_words     = 256;

    // jdo field positions
    localparam int c_jdo_clr_flags = 34;
    localparam int c_jdo_addr_hi   = 33;
    localparam int c_jdo_addr_lo   = 26;
    localparam int c_jdo_load_addr = 25;
    localparam int c_jdo_set_go    = 24;
    localparam int c_jdo_read      = 17;
    localparam int c_jdo_wdata_hi  = 34;
    localparam int c_jdo_wdata_lo  = 3;

    // CPU address bit selecting the register space
    localparam int c_reg_sel_bit   = 8;

    // Status / control register bit indices
    localparam int c_st_ready      = 0;
    localparam int c_st_error      = 1;
    localparam int c_st_go         = 2;
    localparam int c_st_overrun    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_JRD    = 2'd1,
        ST_CPU_RD = 2'd2
    } state_t;

endpackage : uart_kernel_nios2_cpu_debug_mon_ram_ctrl_pkg
`default_nettype wire

// File: rtl/uart_kernel_nios2_cpu_debug_mon_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_kernel_nios2_cpu_debug_mon_ram_ctrl_if
// Purpose  : CPU-side Avalon-MM slave bus of the debug monitor RAM.
//            master : address, read, write, writedata, byteenable (out)
//                     readdata, waitrequest (in)
//            slave  : the reverse
// Revision : 1.0 - initial release
// ============================================================================
interface uart_kernel_nios2_cpu_debug_mon_ram_ctrl_if;
    logic [8:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface : uart_kernel_nios2_cpu_debug_mon_ram_ctrl_if
`default_nettype wire

// File: rtl/uart_kernel_nios2_cpu_debug_mon_ram.sv
`default_nettype none
// ============================================================================
// Module   : uart_kernel_nios2_cpu_debug_mon_ram
// Purpose  : Single-port synchronous debug RAM, byte-enabled writes,
//            one-cycle registered read. No reset so it maps to block RAM.
// Ports    : clk  - clock
//            en   - read enable (q updates on the next edge)
//            addr - word address
//            we   - per-byte write enables
//            d    - write data
//            q    - read data
// Revision : 1.0 - initial release
// ============================================================================
module uart_kernel_nios2_cpu_debug_mon_ram #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  wire logic          clk,
    input  wire logic          en,
    input  wire logic [AW-1:0] addr,
    input  wire logic [3:0]    we,
    input  wire logic [31:0]   d,
    output logic      [31:0]   q
);
    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                r_mem[addr][8*b +: 8] <= d[8*b +: 8];
            end
        end
        if (en) begin
            q <= r_mem[addr];
        end
    end
endmodule : uart_kernel_nios2_cpu_debug_mon_ram
`default_nettype wire

// File: rtl/uart_kernel_nios2_cpu_debug_mon_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_kernel_nios2_cpu_debug_mon_ram_ctrl
// Purpose  : Executes JTAG debug-slave RAM ops (jdo + take_* strobes) on the
//            256x32 debug RAM and arbitrates it against a CPU Avalon port.
// Ports    : clk, reset_n (async, active low)
//            jdo, take_action_ocimem_a, take_no_action_ocimem_a,
//            take_action_ocimem_b          - JTAG side
//            bus (slave modport)           - CPU Avalon-MM port
//            MonDReg, monitor_ready, monitor_error, monitor_go - to debug slave
// Revision : 1.0 - initial release
// ============================================================================
module uart_kernel_nios2_cpu_debug_mon_ram_ctrl
    import uart_kernel_nios2_cpu_debug_mon_ram_ctrl_pkg::*;
#(
    parameter int         RAM_WORDS     = c_ram_words,
    parameter logic [7:0] RESET_MONAREG = 8'h00
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic [37:0] jdo,
    input  wire logic        take_action_ocimem_a,
    input  wire logic        take_no_action_ocimem_a,
    input  wire logic        take_action_ocimem_b,
    uart_kernel_nios2_cpu_debug_mon_ram_ctrl_if.slave bus,
    output logic      [31:0] MonDReg,
    output logic             monitor_ready,
    output logic             monitor_error,
    output logic             monitor_go
);
    state_t      r_state, w_state_nxt;
    logic        r_pend_valid, r_pend_write;
    logic [31:0] r_pend_data;
    logic [7:0]  r_pend_addr;
    logic [7:0]  r_mon_areg;
    logic        r_overrun;
    logic        r_rd_is_reg;

    logic        w_req_a, w_req_n, w_req_b, w_req_any, w_req_multi;
    logic        w_accept, w_drop, w_jtag_busy;
    logic        w_load_addr, w_jtag_clr, w_jtag_go;
    logic        w_ram_en, w_jtag_done, w_cpu_reg_wr, w_launch_rd;
    logic [3:0]  w_ram_we, w_cpu_bits;
    logic [7:0]  w_ram_addr, w_cap_addr;
    logic [31:0] w_ram_d, w_ram_q, w_status;
    logic        w_unused_jdo;

    assign w_unused_jdo = ^{jdo[37:35], jdo[2:0]};

    // Strobe decode; only strobes that queue a RAM op compete for the slot
    assign w_load_addr = take_action_ocimem_a & jdo[c_jdo_load_addr];
    assign w_jtag_clr  = take_action_ocimem_a & jdo[c_jdo_clr_flags];
    assign w_jtag_go   = take_action_ocimem_a & jdo[c_jdo_set_go];
    assign w_req_b     = take_action_ocimem_b;
    assign w_req_a     = take_action_ocimem_a & jdo[c_jdo_read];
    assign w_req_n     = take_no_action_ocimem_a;
    assign w_req_any   = w_req_a | w_req_n | w_req_b;
    assign w_req_multi = (w_req_a & w_req_n) | (w_req_b & (w_req_a | w_req_n));
    assign w_accept    = w_req_any & ~r_pend_valid;
    assign w_drop      = (w_req_any & r_pend_valid) | w_req_multi;
    // A strobe arriving this cycle already blocks the CPU, so a CPU read
    // issued alongside a JTAG write observes the written data.
    assign w_jtag_busy = r_pend_valid | w_req_any;
    // An address loaded by the same op A applies to its queued read
    assign w_cap_addr  = (!w_req_b && w_load_addr) ? jdo[c_jdo_addr_hi:c_jdo_addr_lo]
                                                  : r_mon_areg;

    assign w_status   = {28'b0, r_overrun, monitor_go, monitor_error, monitor_ready};
    assign w_cpu_bits = (w_cpu_reg_wr & bus.byteenable[0]) ? bus.writedata[3:0] : 4'b0;

    always_comb begin
        w_state_nxt  = r_state;
        w_ram_en     = 1'b0;
        w_ram_we     = 4'b0;
        w_ram_addr   = r_pend_addr;
        w_ram_d      = r_pend_data;
        w_jtag_done  = 1'b0;
        w_cpu_reg_wr = 1'b0;
        w_launch_rd  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_valid) begin
                    if (r_pend_write) begin
                        w_ram_we    = 4'hF;
                        w_jtag_done = 1'b1;
                    end else begin
                        w_ram_en    = 1'b1;
                        w_state_nxt = ST_JRD;
                    end
                end else if (!w_req_any) begin
                    w_ram_addr = bus.address[7:0];
                    if (bus.read) begin
                        w_ram_en    = ~bus.address[c_reg_sel_bit];
                        w_launch_rd = 1'b1;
                        w_state_nxt = ST_CPU_RD;
                    end else if (bus.write) begin
                        w_ram_d = bus.writedata;
                        if (bus.address[c_reg_sel_bit]) begin
                            w_cpu_reg_wr = 1'b1;
                        end else begin
                            w_ram_we = bus.byteenable;
                        end
                    end
                end
            end
            ST_JRD: begin
                w_jtag_done = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reads stall through the launch cycle and complete in CPU_RD
    assign bus.waitrequest = ~reset_n
                           | (bus.write & ~((r_state == ST_IDLE) & ~w_jtag_busy))
                           | (bus.read  & (r_state != ST_CPU_RD));
    assign bus.readdata    = (r_state != ST_CPU_RD) ? 32'b0 :
                             (r_rd_is_reg ? w_status : w_ram_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pend_valid <= 1'b0;
            r_pend_write <= 1'b0;
            r_pend_data  <= 32'b0;
            r_pend_addr  <= 8'b0;
            r_rd_is_reg  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch_rd) begin
                r_rd_is_reg <= bus.address[c_reg_sel_bit];
            end
            if (w_jtag_done) begin
                r_pend_valid <= 1'b0;
            end else if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_write <= w_req_b;
                r_pend_data  <= jdo[c_jdo_wdata_hi:c_jdo_wdata_lo];
                r_pend_addr  <= w_cap_addr;
            end
        end
    end

    // Flags: a CPU set beats a JTAG clear; a JTAG set beats a CPU clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            monitor_go    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            monitor_ready <= w_cpu_bits[c_st_ready] | (monitor_ready & ~w_jtag_clr);
            monitor_error <= w_cpu_bits[c_st_error] | (monitor_error & ~w_jtag_clr);
            monitor_go    <= w_jtag_go | (monitor_go & ~w_cpu_bits[c_st_go]);
            r_overrun     <= w_drop | (r_overrun & ~w_cpu_bits[c_st_overrun]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mon_areg <= RESET_MONAREG;
            MonDReg    <= 32'b0;
        end else begin
            if (w_load_addr) begin
                r_mon_areg <= jdo[c_jdo_addr_hi:c_jdo_addr_lo];
            end else if (w_jtag_done) begin
                r_mon_areg <= r_pend_addr + 8'd1;
            end
            if (r_state == ST_JRD) begin
                MonDReg <= w_ram_q;
            end
        end
    end

    uart_kernel_nios2_cpu_debug_mon_ram #(
        .WORDS (RAM_WORDS)
    ) u_ram (
        .clk  (clk),
        .en   (w_ram_en),
        .addr (w_ram_addr),
        .we   (w_ram_we),
        .d    (w_ram_d),
        .q    (w_ram_q)
    );
endmodule : uart_kernel_nios2_cpu_debug_mon_ram_ctrl
`default_nettype wire

// File: tb/tb_uart_kernel_nios2_cpu_debug_mon_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_kernel_nios2_cpu_debug_mon_ram_ctrl
// Purpose  : Scoreboard bench for the debug monitor RAM controller. CPU read
//            data is predicted into a queue and checked by a monitor on each
//            completed read; JTAG results are checked against a word-array
//            model of the RAM and monitor registers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_kernel_nios2_cpu_debug_mon_ram_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_n, take_b;
    logic [31:0] mon_dreg;
    logic        mon_ready, mon_error, mon_go;

    uart_kernel_nios2_cpu_debug_mon_ram_ctrl_if bus ();

    uart_kernel_nios2_cpu_debug_mon_ram_ctrl dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_n),
        .take_action_ocimem_b    (take_b),
        .bus                     (bus),
        .MonDReg                 (mon_dreg),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .monitor_go              (mon_go)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [31:0] m_mem [256];
    logic [7:0]  m_areg;
    logic [31:0] m_dreg;
    logic        m_ready, m_error, m_go, m_ovr;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] m_status();
        return {28'b0, m_ovr, m_go, m_error, m_ready};
    endfunction

    function automatic logic [37:0] rand_jdo();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[37:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every completed CPU read pops one prediction
    always @(negedge clk) begin
        if (reset_n && bus.read && !bus.waitrequest) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cpu_read_unexpected: got %h expected no read", bus.readdata);
            end else begin
                check("cpu_readdata", bus.readdata, exp_q.pop_front());
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!bus.waitrequest) break;
            n++;
            if (n > 30) begin
                n_checks++;
                n_fail++;
                $display("FAIL waitrequest_timeout: got stuck high expected release");
                break;
            end
        end
        tick();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_areg"},  32'(dut.r_mon_areg), 32'(m_areg));
        check({tag, "_dreg"},  mon_dreg, m_dreg);
        check({tag, "_ready"}, 32'(mon_ready), 32'(m_ready));
        check({tag, "_error"}, 32'(mon_error), 32'(m_error));
        check({tag, "_go"},    32'(mon_go), 32'(m_go));
    endtask

    task automatic cpu_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (addr[8]) begin
            if (be[0]) begin
                if (data[0]) m_ready = 1'b1;
                if (data[1]) m_error = 1'b1;
                if (data[2]) m_go    = 1'b0;
                if (data[3]) m_ovr   = 1'b0;
            end
        end else begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_mem[addr[7:0]][8*b +: 8] = data[8*b +: 8];
        end
        bus.address = addr; bus.writedata = data; bus.byteenable = be; bus.write = 1'b1;
        wait_accept();
        bus.write = 1'b0;
    endtask

    task automatic cpu_read(input logic [8:0] addr);
        exp_q.push_back(addr[8] ? m_status() : m_mem[addr[7:0]]);
        bus.address = addr; bus.read = 1'b1;
        wait_accept();
        bus.read = 1'b0;
    endtask

    task automatic jtag_a(input logic load, input logic [7:0] addr, input logic rd,
                          input logic clr, input logic go);
        logic [37:0] j;
        j = rand_jdo();
        j[34] = clr; j[33:26] = addr; j[25] = load; j[24] = go; j[17] = rd;
        if (clr) begin m_ready = 1'b0; m_error = 1'b0; end
        if (load) m_areg = addr;
        if (go) m_go = 1'b1;
        if (rd) begin m_dreg = m_mem[m_areg]; m_areg = m_areg + 8'd1; end
        jdo = j; take_a = 1'b1;
        tick();
        take_a = 1'b0;
        repeat (3) tick();
        check_state("jtag_a");
    endtask

    task automatic jtag_stream();
        jdo = rand_jdo();
        m_dreg = m_mem[m_areg];
        m_areg = m_areg + 8'd1;
        take_n = 1'b1;
        tick();
        take_n = 1'b0;
        repeat (3) tick();
        check_state("jtag_stream");
    endtask

    task automatic jtag_b(input logic [31:0] data);
        logic [37:0] j;
        j = rand_jdo();
        j[34:3] = data;
        m_mem[m_areg] = data;
        m_areg = m_areg + 8'd1;
        jdo = j; take_b = 1'b1;
        tick();
        take_b = 1'b0;
        repeat (3) tick();
        check("jtag_b_areg", 32'(dut.r_mon_areg), 32'(m_areg));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] j;
        logic [31:0] d1, d2, old41;
        reset_n = 1'b0; jdo = '0; take_a = 0; take_n = 0; take_b = 0;
        bus.address = '0; bus.read = 0; bus.write = 0; bus.writedata = '0; bus.byteenable = '0;
        m_areg = 8'h00; m_dreg = '0; m_ready = 0; m_error = 0; m_go = 0; m_ovr = 0;
        repeat (3) tick();
        check("reset_waitrequest", 32'(bus.waitrequest), 32'd1);
        check("reset_readdata", bus.readdata, 32'd0);
        check_state("reset");
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) cpu_write({1'b0, 8'(i)}, $urandom(), 4'hF);

        // JTAG write then read back
        jtag_a(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        jtag_b(32'hDEADBEEF);
        jtag_a(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        check("readback_dreg", mon_dreg, 32'hDEADBEEF);
        check("readback_areg", 32'(dut.r_mon_areg), 32'h11);

        // Streaming read wraps at the top of the RAM
        jtag_a(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        jtag_stream();
        jtag_stream();
        check("wrap_areg", 32'(dut.r_mon_areg), 32'h01);

        // Flags
        cpu_write(9'h100, 32'h3, 4'hF);
        cpu_read(9'h100);
        jtag_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cpu_read(9'h100);
        cpu_write(9'h100, 32'h4, 4'hF);
        cpu_read(9'h100);
        check("flags_go_cleared", 32'(mon_go), 32'd0);

        // Contention: CPU read and JTAG write to the same word in one cycle
        jtag_a(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        j = rand_jdo(); j[34:3] = 32'h12345678;
        m_mem[8'h10] = 32'h12345678; m_areg = m_areg + 8'd1;
        exp_q.push_back(32'h12345678);
        bus.address = 9'h010; bus.read = 1'b1; jdo = j; take_b = 1'b1;
        @(negedge clk);
        check("contention_wait", 32'(bus.waitrequest), 32'd1);
        tick();
        take_b = 1'b0;
        wait_accept();
        bus.read = 1'b0;
        repeat (2) tick();

        // Overrun: second write strobe lands while the slot is still full
        jtag_a(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        old41 = m_mem[8'h41];
        d1 = $urandom(); d2 = $urandom();
        exp_q.push_back(m_mem[8'h80]);
        bus.address = 9'h080; bus.read = 1'b1;
        tick();
        j = rand_jdo(); j[34:3] = d1; jdo = j; take_b = 1'b1;
        tick();
        bus.read = 1'b0;
        j = rand_jdo(); j[34:3] = d2; jdo = j;
        tick();
        take_b = 1'b0;
        m_mem[8'h40] = d1; m_areg = 8'h41; m_ovr = 1'b1;
        repeat (3) tick();
        check("overrun_areg", 32'(dut.r_mon_areg), 32'h41);
        cpu_read(9'h100);
        cpu_read(9'h040);
        cpu_read(9'h041);
        check("overrun_model_old", m_mem[8'h41], old41);
        cpu_write(9'h100, 32'h8, 4'h1);
        cpu_read(9'h100);

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 6))
                0: cpu_write({1'b0, 8'($urandom())}, $urandom(), 4'($urandom()));
                1: cpu_read({1'b0, 8'($urandom())});
                2: cpu_read({1'b1, 8'($urandom())});
                3: cpu_write({1'b1, 8'($urandom())}, 32'($urandom_range(0, 15)), 4'($urandom()));
                4: jtag_a(1'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
                5: jtag_stream();
                default: jtag_b($urandom());
            endcase
        end

        // Reset during the JRD cycle
        jtag_a(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        jtag_b(32'hCAFEF00D);
        j = rand_jdo(); j[33:26] = 8'h20; j[25] = 1'b1; j[17] = 1'b1; j[34] = 1'b0; j[24] = 1'b0;
        jdo = j; take_a = 1'b1;
        tick();
        take_a = 1'b0;
        tick();
        reset_n = 1'b0;
        m_areg = 8'h00; m_dreg = '0; m_ready = 0; m_error = 0; m_go = 0; m_ovr = 0;
        @(negedge clk);
        check("rst_jrd_waitrequest", 32'(bus.waitrequest), 32'd1);
        check_state("rst_jrd");
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_state("rst_release");
        cpu_read(9'h020);
        cpu_read(9'h100);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_uart_kernel_nios2_cpu_debug_mon_ram_ctrl
`default_nettype wire
